// File: rtl/csc_out_sequencer.sv
// csc_out_sequencer: serializes NPIX-pixel YCoCg groups through one shared YCoCg->RGB converter, clamps and streams 12b RGB.
// Optional clamp counter enabled by defining VDCM_CLIP_CNT_EN.
module csc_out_sequencer #(
    parameter int NPIX = 2
`ifdef VDCM_CLIP_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           cfg_bpc,
    input  logic                 cfg_csc_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NPIX*14-1:0]   in_y,
    input  logic [NPIX*14-1:0]   in_co,
    input  logic [NPIX*14-1:0]   in_cg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [11:0]          out_r,
    output logic [11:0]          out_g,
    output logic [11:0]          out_b,
    output logic                 out_last
`ifdef VDCM_CLIP_CNT_EN
    , output logic [CNT_W-1:0]   clip_count
`endif
);
    localparam int IW = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam logic [IW-1:0] LAST = IW'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_n;

    logic [IW-1:0] idx;
    logic [3:0] bpc_q, bpc_s;
    logic csc_q, csc_s;
    logic signed [13:0] buf_y [NPIX];
    logic signed [13:0] buf_co [NPIX];
    logic signed [13:0] buf_cg [NPIX];
    logic signed [13:0] cy, cco, ccg, t, gg, bb, rr, vr, vg, vb;
    logic [11:0] maxp;
    logic hs, take, load_in, adv, load;

    function automatic logic [3:0] norm_bpc(input logic [3:0] b);
        return (b == 4'd10 || b == 4'd12) ? b : 4'd8;
    endfunction

    function automatic logic [11:0] clamp(input logic signed [13:0] v, input logic [11:0] m);
        return v[13] ? 12'd0 : ($unsigned(v) > {2'b0, m}) ? m : v[11:0];
    endfunction

    assign hs = out_valid & out_ready;
    assign in_ready = !rst & (state == IDLE | (state == DRAIN & out_ready));
    assign take = in_valid & in_ready;
    // A DRAIN-state accept feeds pixel 0 straight into the converter so consecutive groups have no bubble
    assign load_in = take & (state == DRAIN);
    assign adv = (state == RUN) & (!out_valid | out_ready);
    assign load = adv | load_in;

    always_comb begin
        cy = load_in ? in_y[13:0] : buf_y[idx];
        cco = load_in ? in_co[13:0] : buf_co[idx];
        ccg = load_in ? in_cg[13:0] : buf_cg[idx];
        bpc_s = load_in ? norm_bpc(cfg_bpc) : bpc_q;
        csc_s = load_in ? cfg_csc_en : csc_q;
        maxp = bpc_s == 4'd12 ? 12'hFFF : bpc_s == 4'd10 ? 12'h3FF : 12'h0FF;
        t = cy - (ccg >>> 1);
        gg = ccg + t;
        bb = t - (cco >>> 1);
        rr = bb + cco;
        vr = csc_s ? rr : cy;
        vg = csc_s ? gg : cco;
        vb = csc_s ? bb : ccg;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = take ? RUN : IDLE;
            RUN:     state_n = (adv && idx == LAST) ? DRAIN : RUN;
            DRAIN:   state_n = !hs ? DRAIN : !take ? IDLE : (NPIX == 1) ? DRAIN : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (take)
            for (int i = 0; i < NPIX; i++) begin
                buf_y[i] <= in_y[14*i +: 14];
                buf_co[i] <= in_co[14*i +: 14];
                buf_cg[i] <= in_cg[14*i +: 14];
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            bpc_q <= 4'd8;
            csc_q <= 1'b1;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_r <= '0;
            out_g <= '0;
            out_b <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                bpc_q <= norm_bpc(cfg_bpc);
                csc_q <= cfg_csc_en;
                idx <= load_in ? IW'(1) : '0;
            end else if (adv) begin
                idx <= idx + 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_last <= load_in ? 1'(NPIX == 1) : (idx == LAST);
                out_r <= clamp(vr, maxp);
                out_g <= clamp(vg, maxp);
                out_b <= clamp(vb, maxp);
            end else if (hs) begin
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

`ifdef VDCM_CLIP_CNT_EN
    // Flags travel with the registered pixel and are counted when that pixel is handed off
    logic [2:0] clip_q;
    logic [1:0] nclip;
    logic [CNT_W:0] sum;
    logic clip_r, clip_g, clip_b;

    assign clip_r = vr[13] | ($unsigned(vr) > {2'b0, maxp});
    assign clip_g = vg[13] | ($unsigned(vg) > {2'b0, maxp});
    assign clip_b = vb[13] | ($unsigned(vb) > {2'b0, maxp});
    assign nclip = {1'b0, clip_q[0]} + {1'b0, clip_q[1]} + {1'b0, clip_q[2]};
    assign sum = {1'b0, clip_count} + (CNT_W+1)'(nclip);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_q <= '0;
            clip_count <= '0;
        end else begin
            if (load)
                clip_q <= {clip_r, clip_g, clip_b};
            if (hs)
                clip_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_csc_out_sequencer.sv
// tb_csc_out_sequencer: directed checks of csc_out_sequencer with NPIX=2.
module tb_csc_out_sequencer;
    logic clk = 0, rst = 1;
    logic [3:0] cfg_bpc = 4'd8;
    logic cfg_csc_en = 1;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_last;
    logic [27:0] in_y = '0, in_co = '0, in_cg = '0;
    logic [11:0] out_r, out_g, out_b;
    int checks = 0, errors = 0;
`ifdef VDCM_CLIP_CNT_EN
    logic [15:0] clip_count;
`endif

    csc_out_sequencer dut (
        .clk(clk), .rst(rst), .cfg_bpc(cfg_bpc), .cfg_csc_en(cfg_csc_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_co(in_co), .in_cg(in_cg),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_last(out_last)
`ifdef VDCM_CLIP_CNT_EN
        , .clip_count(clip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int y0, co0, cg0, y1, co1, cg1, input int bpc, input bit csc);
        in_y = {14'(y1), 14'(y0)};
        in_co = {14'(co1), 14'(co0)};
        in_cg = {14'(cg1), 14'(cg0)};
        cfg_bpc = 4'(bpc);
        cfg_csc_en = csc;
        in_valid = 1;
    endtask

    task automatic pix(input string tag, input int r, g, b, input bit last);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".r"}, 32'(out_r), r);
        chk({tag, ".g"}, 32'(out_g), g);
        chk({tag, ".b"}, 32'(out_b), b);
        chk({tag, ".last"}, 32'(out_last), 32'(last));
    endtask

    task automatic group(input string tag, input int y0, co0, cg0, y1, co1, cg1, bpc, input bit csc,
                         input int r0, g0, b0, r1, g1, b1);
        drive(y0, co0, cg0, y1, co1, cg1, bpc, csc);
        out_ready = 1;
        cyc();
        in_valid = 0;
        chk({tag, ".busy_ready"}, 32'(in_ready), 0);
        chk({tag, ".lat_valid"}, 32'(out_valid), 0);
        cyc();
        pix({tag, ".p0"}, r0, g0, b0, 0);
        cyc();
        pix({tag, ".p1"}, r1, g1, b1, 1);
        chk({tag, ".drain_ready"}, 32'(in_ready), 1);
        cyc();
        chk({tag, ".idle_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        cyc();
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_r", 32'(out_r), 0);
        chk("rst.out_last", 32'(out_last), 0);
        rst = 0;
        #1;
        chk("rel.in_ready", 32'(in_ready), 1);

        group("a", 100, 20, 10, 300, 0, 0, 8, 1, 105, 105, 85, 255, 255, 255);
        group("b", 4000, 0, 0, -10, 0, 0, 12, 1, 4000, 4000, 4000, 0, 0, 0);
        group("c", 1100, 0, 0, 1023, 0, 0, 10, 1, 1023, 1023, 1023, 1023, 1023, 1023);
        group("d", 5, 2000, -1, 0, 255, 4095, 10, 0, 5, 1023, 0, 0, 255, 1023);
        group("bpc5", 300, 0, 0, 255, 0, 0, 5, 1, 255, 255, 255, 255, 255, 255);

        // backpressure on both pixels; cfg change mid-group must not apply
        drive(100, 20, 10, 300, 0, 0, 8, 1);
        out_ready = 0;
        cyc();
        in_valid = 0;
        cfg_bpc = 12;
        cfg_csc_en = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            pix("bp.p0", 105, 105, 85, 0);
        end
        out_ready = 1;
        cyc();
        pix("bp.p1first", 255, 255, 255, 1);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            pix("bp.p1hold", 255, 255, 255, 1);
            chk("bp.in_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        cyc();
        chk("bp.done_valid", 32'(out_valid), 0);

        // back-to-back: groups alternate bpc 8/12, cfg switches right after each accept
        drive(1, 0, 0, 300, 0, 0, 8, 1);
        cyc();
        drive(11, 0, 0, 300, 0, 0, 12, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            pix("b2b.p0", 10 * k + 1, 10 * k + 1, 10 * k + 1, 0);
            if (k > 0) begin
                if (k == 3) in_valid = 0;
                else drive(10 * (k + 1) + 1, 0, 0, 300, 0, 0, (k % 2 == 1) ? 8 : 12, 1);
            end
            cyc();
            pix("b2b.p1", (k % 2 == 1) ? 300 : 255, (k % 2 == 1) ? 300 : 255, (k % 2 == 1) ? 300 : 255, 1);
            chk("b2b.in_ready", 32'(in_ready), 1);
        end
        cyc();
        chk("b2b.end_valid", 32'(out_valid), 0);

        // asynchronous reset mid-group
        drive(100, 20, 10, 50, 0, 0, 8, 1);
        cyc();
        in_valid = 0;
        cyc();
        pix("mid.p0", 105, 105, 85, 0);
        #2 rst = 1;
        #1;
        chk("mid.rst_valid", 32'(out_valid), 0);
        chk("mid.rst_r", 32'(out_r), 0);
        chk("mid.rst_ready", 32'(in_ready), 0);
        cyc();
        rst = 0;
        #1;
        chk("mid.rel_ready", 32'(in_ready), 1);
        cyc();
        chk("mid.no_resume", 32'(out_valid), 0);
        group("post", 7, 0, 0, 8, 0, 0, 8, 1, 7, 7, 7, 8, 8, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
